// File: rtl/serial_adder_pkg.sv
// Shared types and default sizing for the digit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultDigit = 1;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder cell; chained DIGIT times to form the per-cycle ripple.
module fa_cell (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Carry
);

  assign Sum   = A ^ B ^ Cin;
  assign Carry = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: DIGIT bits per cycle, result after WIDTH/DIGIT RUN cycles.
// Define SERIAL_ADDER_SUB_EN to add the Sub port (A + ~B + 1, Cin ignored).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DIGIT = DefaultDigit
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             busy,
  output logic             done
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = $clog2(N + 1);

  state_e            state_q;
  logic [WIDTH-1:0]  a_q, b_q, psum_q, sum_q;
  logic              c_q, carry_q, busy_q, done_q;
  logic [CntW-1:0]   cnt_q;

  logic [WIDTH-1:0]  b_ld;
  logic              c_ld;
  logic [DIGIT:0]    chain;
  logic [DIGIT-1:0]  dsum;
  logic [WIDTH-1:0]  psum_next;

  // Subtraction is folded in at load time so the datapath only ever adds.
  always_comb begin
    b_ld = B;
    c_ld = Cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (Sub) begin
      b_ld = ~B;
      c_ld = 1'b1;
    end
`endif
  end

  assign chain[0] = c_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    fa_cell u_fa (
      .A    (a_q[i]),
      .B    (b_q[i]),
      .Cin  (chain[i]),
      .Sum  (dsum[i]),
      .Carry(chain[i+1])
    );
  end

  // New digit enters at the MSB end; after N shifts the LSB digit sits at bit 0.
  assign psum_next = (psum_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      psum_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= b_ld;
            c_q     <= c_ld;
            psum_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q    <= a_q >> DIGIT;
          b_q    <= b_q >> DIGIT;
          c_q    <= chain[DIGIT];
          psum_q <= psum_next;
          cnt_q  <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(N - 1)) begin
            sum_q   <= psum_next;
            carry_q <= chain[DIGIT];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Sum   = sum_q;
  assign Carry = carry_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder in three configurations (8/1, 8/4, 4/2).
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=8, DIGIT=1
  logic       rst8, start8, cin8, carry8, busy8, done8;
  logic [7:0] a8, b8, sum8;
  // WIDTH=8, DIGIT=4
  logic       rst_n, start84, cin84, carry84, busy84, done84;
  logic [7:0] a84, b84, sum84;
  // WIDTH=4, DIGIT=2
  logic       start4, cin4, carry4, busy4, done4;
  logic [3:0] a4, b4, sum4;
`ifdef SERIAL_ADDER_SUB_EN
  logic sub8 = 1'b0, sub84 = 1'b0, sub4 = 1'b0;
`endif

  serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst_n(rst8), .start(start8), .A(a8), .B(b8), .Cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub(sub8),
`endif
    .Sum(sum8), .Carry(carry8), .busy(busy8), .done(done8)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u84 (
    .clk(clk), .rst_n(rst_n), .start(start84), .A(a84), .B(b84), .Cin(cin84),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub(sub84),
`endif
    .Sum(sum84), .Carry(carry84), .busy(busy84), .done(done84)
  );

  serial_adder #(.WIDTH(4), .DIGIT(2)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4), .Cin(cin4),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub(sub4),
`endif
    .Sum(sum4), .Carry(carry4), .busy(busy4), .done(done4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each start task returns just after the accepting edge.
  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait8(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done8 && k < 40);
  endtask

  int k, pulses, first_k, busyc;

  initial begin
    rst8 = 1'b0; rst_n = 1'b0;
    start8 = 0; start84 = 0; start4 = 0;
    a8 = 0; b8 = 0; cin8 = 0; a84 = 0; b84 = 0; cin84 = 0; a4 = 0; b4 = 0; cin4 = 0;
    repeat (2) @(negedge clk);
    chk("reset_sum", 32'(sum8), 32'h0);
    chk("reset_carry", 32'(carry8), 32'h0);
    chk("reset_busy", 32'(busy8), 32'h0);
    chk("reset_done", 32'(done8), 32'h0);
    rst8 = 1'b1; rst_n = 1'b1;

    // FF + 01 + 0 = 0x100
    go8(8'hFF, 8'h01, 1'b0);
    chk("t1_busy", 32'(busy8), 32'h1);
    wait8(k);
    chk("t1_latency", 32'(k), 32'd8);
    chk("t1_result", 32'({carry8, sum8}), 32'h100);
    @(negedge clk);
    chk("t1_done_one_cycle", 32'(done8), 32'h0);
    chk("t1_busy_after", 32'(busy8), 32'h0);

    // 5A + 3C + 1 = 0x97 on the 4-bit digit build
    @(negedge clk);
    a84 = 8'h5A; b84 = 8'h3C; cin84 = 1'b1; start84 = 1'b1;
    @(negedge clk);
    start84 = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done84 && k < 20);
    chk("t2_latency", 32'(k), 32'd2);
    chk("t2_result", 32'({carry84, sum84}), 32'h097);

    // Second start and operand change during RUN must not disturb 33+44+1
    go8(8'h33, 8'h44, 1'b1);
    pulses = 0; first_k = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 3) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      end
      if (i == 4) start8 = 1'b0;
      if (done8) begin
        pulses++;
        if (first_k == 0) first_k = i;
      end
    end
    chk("t3_pulses", 32'(pulses), 32'd1);
    chk("t3_latency", 32'(first_k), 32'd8);
    chk("t3_result", 32'({carry8, sum8}), 32'h078);

    // Reset at RUN cycle 3 aborts; prior result 0x78 is cleared
    go8(8'h12, 8'h34, 1'b0);
    repeat (2) @(negedge clk);
    rst8 = 1'b0;
    @(negedge clk);
    chk("t4_busy", 32'(busy8), 32'h0);
    chk("t4_done", 32'(done8), 32'h0);
    chk("t4_result", 32'({carry8, sum8}), 32'h000);
    rst8 = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) pulses++;
    end
    chk("t4_no_done", 32'(pulses), 32'd0);
    go8(8'h80, 8'h80, 1'b1);
    wait8(k);
    chk("t4_restart_latency", 32'(k), 32'd8);
    chk("t4_restart_result", 32'({carry8, sum8}), 32'h101);

`ifdef SERIAL_ADDER_SUB_EN
    // 10 - 20 = F0 with borrow (Carry=0); Cin ignored
    sub8 = 1'b1;
    go8(8'h10, 8'h20, 1'b0);
    sub8 = 1'b0;
    wait8(k);
    chk("sub_latency", 32'(k), 32'd8);
    chk("sub_result", 32'({carry8, sum8}), 32'h0F0);
`endif

    // Exhaustive 4-bit sweep, two digits of two bits
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          @(negedge clk);
          a4 = 4'(a); b4 = 4'(b); cin4 = 1'(c); start4 = 1'b1;
          @(negedge clk);
          start4 = 1'b0;
          busyc = busy4 ? 1 : 0;
          k = 0;
          do begin
            @(negedge clk);
            k++;
            if (busy4) busyc++;
          end while (!done4 && k < 10);
          chk("sweep_latency", 32'(k), 32'd2);
          chk("sweep_result", 32'({carry4, sum4}), 32'(a + b + c));
          chk("sweep_busy", 32'(busyc), 32'd2);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 1, giving the bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-006 The block SHALL have ports A and B, input, WIDTH bits each: the operands.
REQ-007 The block SHALL have port Cin, input, 1 bit: the carry-in.
REQ-008 The block SHALL have port Sum, output, WIDTH bits: the registered result.
REQ-009 The block SHALL have port Carry, output, 1 bit: the registered carry-out of the MSB.
REQ-010 The block SHALL have port busy, output, 1 bit: high in RUN.
REQ-011 The block SHALL have port done, output, 1 bit: a one-cycle completion pulse, high in DONE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE, start=1 at a rising edge SHALL do all of the following: latch A, B and Cin into internal shift registers; clear the digit counter; enter RUN.
REQ-014 In RUN, each cycle SHALL add the low DIGIT bits of the shifted operands plus the carry flop, using a ripple of DIGIT full-adder cells.
REQ-015 In RUN, each cycle SHALL shift the DIGIT result bits into the MSB end of the partial-sum register.
REQ-016 In RUN, each cycle SHALL update the carry flop and increment the counter.
REQ-017 After N = WIDTH/DIGIT RUN cycles, the block SHALL copy the partial sum to Sum and the carry flop to Carry, and enter DONE.
REQ-018 done SHALL therefore rise exactly N rising edges after the edge that accepted start.
REQ-019 DONE SHALL last exactly one cycle and SHALL return to IDLE unconditionally.
REQ-020 start in RUN or DONE SHALL be ignored, with no queuing.
REQ-021 Sum and Carry SHALL change only on the transition into DONE and SHALL hold until the next completion.
REQ-022 Changes on A, B and Cin after acceptance SHALL have no effect on the operation in progress.
REQ-023 The counter SHALL be $clog2(N+1) bits wide and SHALL not wrap within an operation.
REQ-024 {Carry, Sum} SHALL equal A + B + Cin, computed exactly modulo 2^(WIDTH+1).

Reset
REQ-025 On rising clk with rst_n=0, the block SHALL force IDLE and clear the counter, the carry flop and the operand/partial-sum registers.
REQ-026 Reset SHALL clear Sum to 0, Carry to 0, busy to 0 and done to 0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation, with no done pulse and no update of Sum or Carry.

Configuration
REQ-028 With macro SERIAL_ADDER_SUB_EN defined, the block SHALL add input port Sub (1 bit), latched with the operands at start.
REQ-029 With SERIAL_ADDER_SUB_EN defined and Sub=1, the block SHALL compute A + ~B + 1, with Cin ignored and Carry = 1 meaning no borrow.
REQ-030 With SERIAL_ADDER_SUB_EN undefined, port Sub SHALL not exist and the block SHALL perform addition only.

Structure
REQ-031 A shared package serial_adder_pkg SHALL hold the state enumeration (IDLE/RUN/DONE) and the default WIDTH/DIGIT constants.
REQ-032 One sub-module, fa_cell (1-bit full adder: A, B, Cin -> Sum, Carry), SHALL be instantiated DIGIT times via generate.

Verification
REQ-033 The bench SHALL cover (WIDTH=8, DIGIT=1) start with A=8'hFF, B=8'h01, Cin=0 -> done 8 edges later, Sum=8'h00, Carry=1.
REQ-034 The bench SHALL cover (WIDTH=8, DIGIT=4) A=8'h5A, B=8'h3C, Cin=1 -> done 2 edges after start, Sum=8'h97, Carry=0.
REQ-035 The bench SHALL cover (WIDTH=8, DIGIT=1) a second start pulse plus an A change during RUN -> result still from the original operands, exactly one done pulse.
REQ-036 The bench SHALL cover rst_n=0 at RUN cycle 3 -> busy=0, done never pulses, Sum/Carry=0; a new start then completes normally.
REQ-037 The bench SHALL cover, with SERIAL_ADDER_SUB_EN, A=8'h10, B=8'h20, Sub=1 -> Sum=8'hF0, Carry=0 (borrow).
REQ-038 The bench SHALL cover an exhaustive sweep (WIDTH=4, DIGIT=2) of all A, B and Cin -> {Carry,Sum} == A+B+Cin every run, and busy high for exactly 2 cycles per run.
